// File: rtl/mac_operand_feeder.sv
// Operand-pair FIFO plus launch FSM that streams a counted burst of pairs into a MAC and returns its result.
// Optional FEEDER_FLUSH_EN adds a flush input that empties the FIFO while IDLE or WAIT.
module mac_operand_feeder #(
  parameter int DEPTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [7:0]  in_a,
  input  logic signed [7:0]  in_b,
  input  logic               go,
  input  logic [4:0]         len,
  output logic               busy,
  output logic               err,
  output logic               mac_start,
  output logic [4:0]         mac_count,
  output logic signed [7:0]  mac_opA,
  output logic signed [7:0]  mac_opB,
  input  logic               mac_finish,
  input  logic signed [15:0] mac_out,
  output logic [15:0]        result,
  output logic               result_valid,
  input  logic               result_ready,
`ifdef FEEDER_FLUSH_EN
  input  logic               flush,
`endif
  output logic [5:0]         level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {IDLE, WAIT, START, STREAM, DRAIN, HOLD} state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg, rd_addr;
  logic [LW-1:0]   level_reg;
  logic [4:0]      len_reg, cnt_reg;
  logic [15:0]     mem [DEPTH];
  logic [15:0]     head_reg;
  logic [15:0]     result_reg;
  logic            result_valid_reg, err_reg;
  logic            push, pop, flush_now, launch_ok;

`ifdef FEEDER_FLUSH_EN
  assign flush_now = flush && (state_reg == IDLE || state_reg == WAIT);
`else
  assign flush_now = 1'b0;
`endif

  assign in_ready     = level_reg < LW'(DEPTH);
  assign push         = in_valid && in_ready && !flush_now;
  assign launch_ok    = (state_reg == IDLE) && go && (len != 5'd0);
  assign busy         = state_reg != IDLE;
  assign err          = err_reg;
  assign result       = result_reg;
  assign result_valid = result_valid_reg;
  assign level        = level_reg[5:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    mac_start  = 1'b0;
    mac_count  = 5'd0;
    mac_opA    = '0;
    mac_opB    = '0;
    case (state_reg)
      IDLE:   if (launch_ok) state_next = (level_reg >= LW'(len)) ? START : WAIT;
      WAIT:   if (level_reg >= LW'(len_reg)) state_next = START;
      START: begin
        mac_start  = 1'b1;
        mac_count  = len_reg;
        state_next = STREAM;
      end
      STREAM: begin
        pop     = 1'b1;
        mac_opA = head_reg[15:8];
        mac_opB = head_reg[7:0];
        if (cnt_reg == 5'd1) state_next = DRAIN;
      end
      DRAIN:  if (mac_finish) state_next = HOLD;
      HOLD:   if (result_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush_now) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      level_reg        <= '0;
      len_reg          <= '0;
      cnt_reg          <= '0;
      err_reg          <= 1'b0;
      result_reg       <= '0;
      result_valid_reg <= 1'b0;
    end else begin
      err_reg <= (state_reg == IDLE) && go && (len == 5'd0);
      if (launch_ok) len_reg <= len;
      if (state_reg == START) cnt_reg <= len_reg;
      else if (pop)           cnt_reg <= cnt_reg - 5'd1;

      if (flush_now) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        level_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
        case ({push, pop})
          2'b10:   level_reg <= level_reg + LW'(1);
          2'b01:   level_reg <= level_reg - LW'(1);
          default: level_reg <= level_reg;
        endcase
      end

      if (state_reg == DRAIN && mac_finish) begin
        result_reg       <= mac_out;
        result_valid_reg <= 1'b1;
      end else if (state_reg == HOLD && result_ready) begin
        result_valid_reg <= 1'b0;
      end
    end
  end

  // Head is prefetched: read in START for the first pop, then one ahead while streaming.
  // Every entry a burst reads was written before START, so no read-during-write hazard exists.
  assign rd_addr = pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= {in_a, in_b};
    head_reg <= mem[rd_addr];
  end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Randomized bench for mac_operand_feeder; a queue of pushed pairs serves as the reference FIFO.
module tb_mac_operand_feeder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid, in_ready, go, busy, err, mac_start, mac_finish;
  logic        result_valid, result_ready;
  logic [7:0]  in_a, in_b, mac_opA, mac_opB;
  logic [4:0]  len, mac_count;
  logic [15:0] mac_out, result;
  logic [5:0]  level;
`ifdef FEEDER_FLUSH_EN
  logic        flush = 1'b0;
`endif

  typedef struct {logic [7:0] a; logic [7:0] b;} pair_t;
  pair_t q[$];
  int n_checks = 0;
  int n_pass   = 0;

  mac_operand_feeder #(.DEPTH(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .go(go), .len(len), .busy(busy), .err(err),
    .mac_start(mac_start), .mac_count(mac_count), .mac_opA(mac_opA), .mac_opB(mac_opB),
    .mac_finish(mac_finish), .mac_out(mac_out),
    .result(result), .result_valid(result_valid), .result_ready(result_ready),
`ifdef FEEDER_FLUSH_EN
    .flush(flush),
`endif
    .level(level)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
    logic acc;
    in_valid = 1'b1; in_a = a; in_b = b;
    acc = in_ready;
    tick();
    in_valid = 1'b0;
    if (acc) q.push_back('{a: a, b: b});
    chk("level_push", level, q.size());
  endtask

  task automatic launch(input int n);
    $display("launch len=%0d queued=%0d", n, q.size());
    go = 1'b1; len = 5'(n);
    tick();
    go = 1'b0; len = 5'd0;
  endtask

  // Entered while the DUT shows its START cycle.
  task automatic stream_run(input int n, input bit rand_push);
    logic acc;
    pair_t p;
    chk("mac_start", mac_start, 1);
    chk("mac_count", mac_count, n);
    chk("opA_start", mac_opA, 0);
    tick();
    for (int i = 0; i < n; i++) begin
      chk("start_low", mac_start, 0);
      chk("count_low", mac_count, 0);
      chk("opA", mac_opA, q[0].a);
      chk("opB", mac_opB, q[0].b);
      acc = 1'b0;
      if (rand_push && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom);
        acc = in_ready;
        p.a = in_a; p.b = in_b;
      end
      tick();
      in_valid = 1'b0;
      void'(q.pop_front());
      if (acc) q.push_back(p);
      chk("level_stream", level, q.size());
    end
    chk("opA_drain", mac_opA, 0);
    chk("opB_drain", mac_opB, 0);
    chk("busy_drain", busy, 1);
  endtask

  task automatic finish_result(input logic [15:0] val, input int hold);
    mac_finish = 1'b1; mac_out = val;
    tick();
    mac_finish = 1'b0;
    chk("rv_set", result_valid, 1);
    chk("result", result, val);
    for (int i = 0; i < hold; i++) begin
      mac_finish = (i == 0);
      mac_out = ~val;
      tick();
      mac_finish = 1'b0;
      chk("rv_hold", result_valid, 1);
      chk("result_hold", result, val);
      chk("busy_hold", busy, 1);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk("rv_clear", result_valid, 0);
    chk("busy_idle", busy, 0);
  endtask

  task automatic run_burst(input int n, input bit rand_push, input logic [15:0] val, input int hold);
    launch(n);
    if (q.size() < n) begin
      chk("busy_wait", busy, 1);
      chk("start_wait", mac_start, 0);
      for (int k = 0; k < 40 && q.size() < n; k++) push_pair(8'($urandom), 8'($urandom));
      chk("start_wait2", mac_start, 0);
      tick();
    end
    stream_run(n, rand_push);
    finish_result(val, hold);
  endtask

  initial begin
    in_valid = 0; in_a = 0; in_b = 0; go = 0; len = 0;
    mac_finish = 0; mac_out = 0; result_ready = 0;
    #12;
    chk("rst_level", level, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_start", mac_start, 0);
    chk("rst_count", mac_count, 0);
    chk("rst_opA", mac_opA, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_result", result, 0);
    @(negedge clk) reset_n = 1'b1;
    tick();

    // Directed burst of three pairs including a negative operand.
    push_pair(8'd1, 8'd2);
    push_pair(8'd3, 8'd4);
    push_pair(8'hFE, 8'd5);
    run_burst(3, 0, 16'h1234, 2);

    // Rejected launch.
    go = 1'b1; len = 5'd0;
    tick();
    go = 1'b0;
    chk("err_pulse", err, 1);
    chk("err_busy", busy, 0);
    chk("err_start", mac_start, 0);
    tick();
    chk("err_drop", err, 0);
    chk("err_start2", mac_start, 0);

    // mac_finish in IDLE is ignored.
    mac_finish = 1'b1; mac_out = 16'h7777;
    tick();
    mac_finish = 1'b0;
    chk("idle_finish_rv", result_valid, 0);

    // Launch waiting on occupancy, with a stray go while waiting.
    push_pair(8'd10, 8'd11);
    push_pair(8'd12, 8'd13);
    launch(4);
    chk("wait_busy", busy, 1);
    chk("wait_start", mac_start, 0);
    go = 1'b1; len = 5'd0;
    tick();
    go = 1'b0;
    chk("wait_go_err", err, 0);
    push_pair(8'd14, 8'd15);
    chk("wait_start3", mac_start, 0);
    push_pair(8'd16, 8'd17);
    chk("wait_start4", mac_start, 0);
    tick();
    stream_run(4, 1);
    finish_result(16'h0004, 5);

    if (q.size() > 0) run_burst(q.size(), 0, 16'h0101, 0);

    // Full FIFO and two wrapping 31-pair bursts.
    for (int f = 0; f < 2; f++) begin
      while (q.size() < 32) push_pair(8'($urandom), 8'($urandom));
      chk("full_ready", in_ready, 0);
      chk("full_level", level, 32);
      push_pair(8'hAA, 8'h55);
      launch(31);
      stream_run(31, f == 1);
      if (f == 0) chk("level_after31", level, 1);
      finish_result(16'(f + 16'h0200), 1);
    end

    // Randomized bursts.
    for (int it = 0; it < 15; it++) begin
      int np;
      np = $urandom_range(0, 32 - q.size());
      for (int k = 0; k < np; k++) begin
        push_pair(8'($urandom), 8'($urandom));
        if ($urandom_range(0, 3) == 0) tick();
      end
      run_burst($urandom_range(1, 31), 1, 16'($urandom), $urandom_range(0, 3));
    end

    // Asynchronous reset mid-stream, then a fresh run.
    while (q.size() < 3) push_pair(8'($urandom), 8'($urandom));
    launch(3);
    chk("pre_rst_start", mac_start, 1);
    tick();
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_opA", mac_opA, 0);
    chk("arst_opB", mac_opB, 0);
    chk("arst_start", mac_start, 0);
    chk("arst_count", mac_count, 0);
    chk("arst_busy", busy, 0);
    chk("arst_level", level, 0);
    chk("arst_rv", result_valid, 0);
    chk("arst_err", err, 0);
    q.delete();
    @(negedge clk) reset_n = 1'b1;
    tick();
    push_pair(8'h81, 8'h7F);
    push_pair(8'h33, 8'hC4);
    run_burst(2, 0, 16'hBEEF, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mac_operand_feeder.md
MAC_OPERAND_FEEDER -- requirements
Module: mac_operand_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 32, operand-pair FIFO depth; power of two, minimum 32.
REQ-002 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operand pair offered.
REQ-005 SHALL have port in_ready  output  1  FIFO can accept a pair.
REQ-006 SHALL have ports in_a and in_b  input  8 each  signed operand pair.
REQ-007 SHALL have port go  input  1  launch request, sampled in IDLE only.
REQ-008 SHALL have port len  input  5  number of pairs to launch, 1..31.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port err  output  1  one-cycle pulse on a rejected launch.
REQ-011 SHALL have ports mac_start  output  1, and mac_count  output  5  MAC launch command.
REQ-012 SHALL have ports mac_opA and mac_opB  output  8 each  signed operands to the MAC.
REQ-013 SHALL have ports mac_finish  input  1, and mac_out  input  16 signed  MAC completion and result.
REQ-014 SHALL have ports result  output  16, result_valid  output  1, and result_ready  input  1  result handshake.
REQ-015 SHALL have port level  output  6  current FIFO occupancy.

Function
REQ-016 SHALL push one pair on each cycle where in_valid and in_ready are both high; in_ready = (level < DEPTH), independent of pops.
REQ-017 SHALL run the FSM with states IDLE, WAIT, START, STREAM, DRAIN, and HOLD.
REQ-018 SHALL, in IDLE, on go with len = 0: pulse err for one cycle and stay in IDLE.
REQ-019 SHALL, in IDLE, on go with len > 0: latch len, then go to START if level >= len, else go to WAIT.
REQ-020 SHALL, in WAIT, stay until level >= latched len, then go to START; pushes continue meanwhile.
REQ-021 SHALL, in START, drive mac_start = 1 and mac_count = latched len for exactly one cycle, then go to STREAM.
REQ-022 SHALL, in STREAM, pop exactly one pair per cycle for len consecutive cycles; mac_opA/mac_opB = FIFO head, in push order.
REQ-023 SHALL drive mac_opA/mac_opB = 0 in every state other than STREAM, and drive mac_start = 0 and mac_count = 0 outside START.
REQ-024 SHALL, after the last STREAM cycle, go to DRAIN and wait for mac_finish; there is no timeout.
REQ-025 SHALL, on mac_finish in DRAIN, register mac_out into result, set result_valid, and go to HOLD.
REQ-026 SHALL, in HOLD, keep result and result_valid stable until result_ready is high; on that cycle clear result_valid and go to IDLE.
REQ-027 SHALL ignore go outside IDLE, and ignore mac_finish outside DRAIN.
REQ-028 SHALL keep the read/write pointers as log2(DEPTH)-bit wrapping counters and level as a separate counter, updated correctly on simultaneous push and pop.

Reset
REQ-029 SHALL, on reset_n low, immediately return the FSM to IDLE and clear pointers, level, result, result_valid, err, mac_start, mac_count, mac_opA, and mac_opB to 0; FIFO data is not cleared.
REQ-030 SHALL treat reset mid-run (WAIT through HOLD) as discarding the FIFO contents and the pending result.

Configuration
REQ-031 SHALL, when macro FEEDER_FLUSH_EN is defined, add input flush (1 bit): in IDLE or WAIT it zeroes level and pointers next cycle and returns to IDLE; in other states it is ignored.
REQ-032 SHALL, when FEEDER_FLUSH_EN is undefined, have no flush port, and the FIFO empties only through STREAM pops or reset.

Verification
REQ-033 SHALL cover: push (1,2),(3,4),(-2,5); go len=3 -> mac_start one cycle with count=3; opA/opB = 1/2, 3/4, -2/5 on the next 3 cycles; zeros otherwise.
REQ-034 SHALL cover: go len=0 -> err high exactly one cycle, busy stays 0, mac_start never asserted.
REQ-035 SHALL cover: level=2, go len=4 -> WAIT with busy=1; push 2 more -> mac_start on the cycle after level reaches 4.
REQ-036 SHALL cover: mac_finish with mac_out=16'h0004 and result_ready=0 for 5 cycles -> result=4 and result_valid stay stable; result_ready=1 -> result_valid drops next cycle, FSM in IDLE.
REQ-037 SHALL cover: fill 32 pairs -> in_ready=0, level=32; go len=31 -> level=1 after STREAM; pointer wrap checked by a second fill-and-launch.
REQ-038 SHALL cover: reset_n low during STREAM -> all outputs 0 asynchronously, level=0, and a subsequent fresh run is correct.
